// File: rtl/id_stage.sv
// ============================================================================
//  Module   : id_stage
//  Purpose  : Instruction decode stage with a 32-entry pending-write scoreboard
//             that stalls fetch on RAW/WAW hazards until writeback commits.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        flush,
    input  logic        wb_enable,
    input  logic [4:0]  wb_add,
    output logic [4:0]  r1_add,
    output logic [4:0]  r2_add,
    output logic        dec_valid,
    output logic [5:0]  dec_opcode,
    output logic [4:0]  dec_write_add,
    output logic        dec_write_enable,
    output logic [31:0] dec_imm,
    output logic        illegal,
    output logic [15:0] stall_cycles
);

    localparam logic [5:0]  c_op_nop       = 6'h00;
    localparam logic [5:0]  c_op_r_lo      = 6'h01;
    localparam logic [5:0]  c_op_r_hi      = 6'h0F;
    localparam logic [5:0]  c_op_store     = 6'h20;
    localparam logic [15:0] c_stall_cnt_max = 16'hFFFF;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic        w_is_nop;
    logic        w_is_r;
    logic        w_is_i;
    logic        w_is_store;
    logic        w_is_illegal;
    logic        w_reads1;
    logic        w_reads2;
    logic        w_writes;
    logic        w_hazard;
    logic        w_stall;
    logic        w_accept;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] r_pending;

    assign w_opcode = instr[31:26];
    assign w_rd     = instr[25:21];
    assign w_rs1    = instr[20:16];
    assign w_rs2    = instr[15:11];

    assign r1_add   = w_rs1;
    assign r2_add   = w_rs2;

    always_comb begin
        w_is_nop     = (w_opcode == c_op_nop);
        w_is_r       = (w_opcode >= c_op_r_lo) && (w_opcode <= c_op_r_hi);
        w_is_i       = (w_opcode[5:4] == 2'b01);
        w_is_store   = (w_opcode == c_op_store);
        w_is_illegal = ~(w_is_nop | w_is_r | w_is_i | w_is_store);
        w_reads1     = w_is_r | w_is_i | w_is_store;
        w_reads2     = w_is_r | w_is_store;
        w_writes     = w_is_r | w_is_i;
    end

    // Hazards look only at the registered scoreboard: the register file
    // returns the pre-write value in the cycle it is written, so no bypass.
    assign w_hazard = (w_reads1 & r_pending[w_rs1])
                    | (w_reads2 & r_pending[w_rs2])
                    | (w_writes & r_pending[w_rd]);

    assign w_stall     = instr_valid & ~flush & w_hazard;
    assign instr_ready = ~w_stall;
    assign w_accept    = instr_valid & ~flush & ~w_stall;

    assign w_set = (w_accept & w_writes) ? (32'd1 << w_rd)   : 32'd0;
    assign w_clr = wb_enable             ? (32'd1 << wb_add) : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending        <= 32'd0;
            dec_valid        <= 1'b0;
            dec_opcode       <= 6'd0;
            dec_write_add    <= 5'd0;
            dec_write_enable <= 1'b0;
            dec_imm          <= 32'd0;
            illegal          <= 1'b0;
            stall_cycles     <= 16'd0;
        end else begin
            // Set after clear so a same-cycle allocate of a committing register wins.
            r_pending        <= (r_pending & ~w_clr) | w_set;
            dec_valid        <= w_accept;
            dec_write_enable <= w_accept & w_writes;
            illegal          <= w_accept & w_is_illegal;
            if (w_accept) begin
                dec_opcode    <= w_opcode;
                dec_write_add <= w_rd;
                dec_imm       <= {{16{instr[15]}}, instr[15:0]};
            end
            if (w_stall && (stall_cycles != c_stall_cnt_max)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/id_stage.md
# id_stage

Instruction decode stage for the 5-stage pipeline. Sits directly upstream of the register file: it drives the register file read addresses from the incoming instruction, and registers the decoded control fields so they leave the stage on the same clock edge as the register file's registered read data. A 32-entry pending-write scoreboard stalls fetch on RAW/WAW hazards until writeback has committed the value.

## Interface

Parameters:
- none

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- instr  in  32  instruction from fetch
- instr_valid  in  1  instr is meaningful this cycle
- instr_ready  out  1  stage accepts instr this cycle; combinational, equals ~stall
- flush  in  1  discard instr this cycle (branch redirect)
- wb_enable  in  1  writeback commits a register this cycle; same signal as register file write enable
- wb_add  in  5  register committed by writeback
- r1_add  out  5  register file read address 1; combinational, instr[20:16]
- r2_add  out  5  register file read address 2; combinational, instr[15:11]
- dec_valid  out  1  decoded instruction valid; aligned with register file read data
- dec_opcode  out  6  registered opcode
- dec_write_add  out  5  registered destination register
- dec_write_enable  out  1  registered "instruction writes rd"
- dec_imm  out  32  registered sign-extended instr[15:0]
- illegal  out  1  registered one-cycle pulse for an accepted undefined opcode
- stall_cycles  out  16  saturating count of stalled cycles

## Operation

- Fields: opcode = instr[31:26], rd = instr[25:21], rs1 = instr[20:16], rs2 = instr[15:11], imm = instr[15:0].
- Opcode classes:
  - 0x00 NOP: no reads, no write.
  - 0x01–0x0F R-type: reads rs1 and rs2, writes rd.
  - 0x10–0x1F I-type: reads rs1, writes rd.
  - 0x20 store: reads rs1 and rs2, no write.
  - Anything else is illegal: no reads, no write, illegal pulses.
- Register 0 is an ordinary register. It is scoreboarded like every other register.
- Scoreboard pending[31:0]:
  - On acceptance of a writing instruction, set pending[rd].
  - When wb_enable is high, clear pending[wb_add].
  - If set and clear target the same register in one cycle, set wins.
- stall = instr_valid & ~flush & any of:
  - a read source is pending;
  - rd is pending and the instruction writes.
- Stall and flush both use the registered pending vector only. There is no bypass, because the register file returns the pre-write value in the cycle it is written.
- Accept = instr_valid & ~flush & ~stall. On accept, at the next edge:
  - dec_valid = 1;
  - dec_opcode, dec_write_add, dec_imm and dec_write_enable are loaded;
  - illegal = 1 if the opcode is undefined.
- Without accept, at the next edge:
  - dec_valid = 0 (bubble);
  - dec_write_enable = 0;
  - illegal = 0;
  - other dec_* fields hold.
- Flush: the instruction is dropped and no scoreboard bit is set. Existing pending bits are unaffected, because older instructions still write back.
- stall_cycles increments on every cycle with stall = 1 and saturates at 0xFFFF.

## Timing

- Reset values: pending = 0, dec_valid = 0, dec_opcode = 0, dec_write_add = 0, dec_write_enable = 0, dec_imm = 0, illegal = 0, stall_cycles = 0.
- While reset is high:
  - instr_ready follows the combinational stall equation;
  - no state updates except the reset values;
  - wb_enable is ignored.
- Reset mid-stall clears the scoreboard. The next valid instruction is accepted in the first cycle after reset deasserts.
- Latency: an instruction accepted at edge N produces dec_* at edge N. The register file samples r1_add/r2_add at the same edge N, so dec_* and r1_value/r2_value are aligned.
- Stall release: with wb_enable/wb_add committed at edge W, the pending bit is clear after W. instr_ready rises in the cycle after W, and the instruction is accepted at edge W+1. The register file read at W+1 returns the written value.
- Fetch must hold instr stable while instr_ready = 0.

## Test plan

- Reset: assert reset 2 cycles with instr_valid = 1 and opcode 0x01 -> all dec_* = 0, stall_cycles = 0, pending = 0; first post-reset edge gives dec_valid = 1.
- Back-to-back independent instructions:
  - Stimulus: R-type rd=3 rs1=1 rs2=2, then I-type rd=4 rs1=5 imm=0xFFFE.
  - Response: no stall; second cycle shows dec_imm = 0xFFFFFFFE and dec_write_add = 4.
- RAW hazard:
  - Stimulus: R-type rd=7, then R-type rs1=7; pulse wb_enable with wb_add=7 three cycles later.
  - Response: instr_ready = 0 for 3 cycles, stall_cycles = 3, accepted the cycle after writeback.
- Same-cycle set/clear: wb_add=9 with wb_enable while accepting an instruction with rd=9 -> pending[9] = 1 afterwards; a following reader of r9 stalls.
- Flush and illegal:
  - flush with a writing instruction rd=12 -> dec_valid = 0 and a reader of r12 is not stalled.
  - Accepted opcode 0x3F -> illegal pulses for 1 cycle with dec_write_enable = 0.
- Counter saturation: hold a hazard for 70000 cycles -> stall_cycles = 0xFFFF and stays there.
